collision_decider: RTL and testbench
====================================

# collision_decider

Downstream of `background_collision`. Consumes the per-edge max/min/avg RGB statistics for each frame and turns them into debounced per-direction blocking flags (`blocked_top/bottom/right/left`). The sprite movement controller reads those flags. The edges are evaluated one per cycle by a small sequencer, and results are published once per frame with a valid pulse.

## Interface
- `HIT_THR`, default 10'd384: luma threshold, compared against `avg_R+avg_G+avg_B` (range 0..765).
- `HIT_POL`, default 1: 1 means hit when sum >= `HIT_THR`; 0 means hit when sum < `HIT_THR`.
- `DEBOUNCE`, default 2: consecutive hits needed to assert a block. Legal range 1..15.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stats_valid` in 1: one-cycle pulse from upstream when all edge stats are final.
- `stats_top` in 72: packed `{max_R,max_G,max_B,min_R,min_G,min_B,avg_R,avg_G,avg_B}`, with `max_R` in [71:64] and `avg_B` in [7:0].
- `stats_bottom`, `stats_right`, `stats_left` in 72 each: same packing as `stats_top`.
- `clear_ovr` in 1: clears the `overrun` flag.
- `blocked_top`, `blocked_bottom`, `blocked_right`, `blocked_left` out 1: registered blocking flags.
- `result_valid` out 1: one-cycle pulse when the blocking flags update.
- `busy` out 1: high while state != IDLE.
- `overrun` out 1: sticky; set when `stats_valid` arrives while busy.

## Operation
- **States:** IDLE → EVAL_TOP → EVAL_BOTTOM → EVAL_RIGHT → EVAL_LEFT → UPDATE → IDLE. Every state except IDLE lasts exactly one cycle.
- **Accepting a frame:** in IDLE, `stats_valid=1` snapshots all four 72-bit buses into internal registers. Upstream may change the buses afterwards. Only the snapshot is evaluated.
- **Per-edge evaluation (EVAL_x):**
  - 10-bit zero-extended sum of `avg_R+avg_G+avg_B` from the snapshot. No overflow is possible.
  - hit = (sum >= `HIT_THR`) when `HIT_POL`=1, or (sum < `HIT_THR`) when `HIT_POL`=0.
  - Edge `x` has a 4-bit hit counter. On a hit it increments, saturating at `DEBOUNCE`. On a miss it clears to 0.
- **UPDATE:** `blocked_x` ← (hit_cnt_x == `DEBOUNCE`) for all four edges simultaneously. `result_valid` pulses.
- **Overrun:**
  - `stats_valid` outside IDLE is dropped: no snapshot, counters untouched, `overrun` ← 1.
  - `clear_ovr` clears `overrun`. If `clear_ovr` and an overrun event occur in the same cycle, set wins.
- Min/max fields are snapshotted but unused unless hysteresis is compiled in (see Configuration); they are reserved for later rules.
- **Reset (`rst`=0, any time, including mid-evaluation):**
  - State → IDLE.
  - All counters, snapshot, `blocked_*`, `result_valid`, `busy` and `overrun` → 0, immediately (asynchronous).
  - The first frame after reset starts from zero history.

## Timing
- Let E0 be the rising edge that samples `stats_valid=1` in IDLE.
  - EVAL_TOP..EVAL_LEFT span E1..E4.
  - UPDATE is registered at E5.
  - `blocked_*` change and `result_valid=1` in the cycle after E5, for exactly one cycle. Latency is 5 clocks.
- `busy` is high from after E0 until after E5, i.e. 5 cycles. The earliest acceptable next `stats_valid` is sampled at E6.
- Between updates, `blocked_*` hold their values.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- **`COLL_HYST_EN` defined:**
  - Each edge also has a 4-bit miss counter. It increments on a miss (saturating at `DEBOUNCE`) and clears on a hit.
  - A block asserts when hit_cnt == `DEBOUNCE`.
  - Once asserted, a block releases only when miss_cnt == `DEBOUNCE`; otherwise it holds.
  - While blocked, a hit additionally requires that the snapshot `min_R+min_G+min_B` is not the inverse of the threshold side. Otherwise it counts as a miss.
- **`COLL_HYST_EN` undefined:** release happens on the first miss (the behaviour described in Operation). No miss counters are synthesized.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles → all outputs 0, `busy`=0. Release `rst`, then drive `stats_valid` → first `result_valid` appears 5 cycles later.
- **Debounce assert:** `DEBOUNCE`=2, `stats_top` avg fields = 8'h80 each (sum 384), other edges 0, two frames.
  - Frame 1: `blocked_top`=0.
  - Frame 2: `blocked_top`=1, other three flags 0. `result_valid` lasts exactly one cycle.
- **Threshold boundary and saturation:**
  - avg fields 8'h80, 8'h80, 8'h7F (sum 383) for 3 frames → `blocked_top` stays 0.
  - Then sum 765 for 5 frames → asserted from frame 2 onward; the counter stays at 2.
- **Release:** from blocked, one frame with sum 0.
  - Without `COLL_HYST_EN`: `blocked_top`=0 immediately.
  - With `COLL_HYST_EN`: still 1 after the first miss, 0 after the second.
- **Overrun:** pulse `stats_valid` at E0 and again at E2 → second pulse ignored, only one `result_valid`, `overrun`=1. `clear_ovr` → `overrun`=0.
- **Reset mid-operation:** `rst`=0 during EVAL_RIGHT while `blocked_left`=1 → all flags 0 and `busy`=0 asynchronously. No `result_valid` occurs for the aborted frame.

Source files
------------

// File: rtl/collision_decider.sv
// collision_decider: evaluates each edge's average luma once per frame, debounces the hits and
// publishes per-direction blocking flags. Define COLL_HYST_EN for miss-count release hysteresis.
module collision_decider #(
    parameter logic [9:0]  HIT_THR  = 10'd384,
    parameter bit          HIT_POL  = 1'b1,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stats_valid,
    input  logic [71:0] stats_top,
    input  logic [71:0] stats_bottom,
    input  logic [71:0] stats_right,
    input  logic [71:0] stats_left,
    input  logic        clear_ovr,
    output logic        blocked_top,
    output logic        blocked_bottom,
    output logic        blocked_right,
    output logic        blocked_left,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [3:0] DebCnt = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        StIdle,
        StEvalTop,
        StEvalBottom,
        StEvalRight,
        StEvalLeft,
        StUpdate
    } state_e;

    state_e      state_q;
    logic [71:0] snap_q    [4];
    logic [3:0]  hit_cnt_q [4];
    logic [3:0]  blocked_q;

    logic        eval_en;
    logic [1:0]  eval_idx;
    logic [71:0] eval_stats;
    logic [9:0]  avg_sum;
    logic        hit;

`ifdef COLL_HYST_EN
    logic [3:0]  miss_cnt_q [4];
    logic [9:0]  min_sum;
`endif

    function automatic logic on_hit_side(input logic [9:0] sum);
        return HIT_POL ? (sum >= HIT_THR) : (sum < HIT_THR);
    endfunction

    // Edge index 0..3 = top, bottom, right, left.
    always_comb begin
        eval_en  = 1'b1;
        eval_idx = 2'd0;
        unique case (state_q)
            StEvalTop:    eval_idx = 2'd0;
            StEvalBottom: eval_idx = 2'd1;
            StEvalRight:  eval_idx = 2'd2;
            StEvalLeft:   eval_idx = 2'd3;
            default:      eval_en  = 1'b0;
        endcase
    end

    always_comb begin
        eval_stats = snap_q[eval_idx];
        avg_sum    = 10'(eval_stats[23:16]) + 10'(eval_stats[15:8]) + 10'(eval_stats[7:0]);
`ifdef COLL_HYST_EN
        min_sum    = 10'(eval_stats[47:40]) + 10'(eval_stats[39:32]) + 10'(eval_stats[31:24]);
        // A held block only re-confirms if the edge minimum also sits on the hit side.
        hit        = on_hit_side(avg_sum) && (!blocked_q[eval_idx] || on_hit_side(min_sum));
`else
        hit        = on_hit_side(avg_sum);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            blocked_q    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int e = 0; e < 4; e++) begin
                snap_q[e]     <= '0;
                hit_cnt_q[e]  <= '0;
`ifdef COLL_HYST_EN
                miss_cnt_q[e] <= '0;
`endif
            end
        end else begin
            result_valid <= 1'b0;

            if (stats_valid && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end

            if (eval_en) begin
                if (hit) begin
                    if (hit_cnt_q[eval_idx] != DebCnt) begin
                        hit_cnt_q[eval_idx] <= hit_cnt_q[eval_idx] + 4'd1;
                    end
`ifdef COLL_HYST_EN
                    miss_cnt_q[eval_idx] <= '0;
`endif
                end else begin
                    hit_cnt_q[eval_idx] <= '0;
`ifdef COLL_HYST_EN
                    if (miss_cnt_q[eval_idx] != DebCnt) begin
                        miss_cnt_q[eval_idx] <= miss_cnt_q[eval_idx] + 4'd1;
                    end
`endif
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (stats_valid) begin
                        snap_q[0] <= stats_top;
                        snap_q[1] <= stats_bottom;
                        snap_q[2] <= stats_right;
                        snap_q[3] <= stats_left;
                        busy      <= 1'b1;
                        state_q   <= StEvalTop;
                    end
                end
                StEvalTop:    state_q <= StEvalBottom;
                StEvalBottom: state_q <= StEvalRight;
                StEvalRight:  state_q <= StEvalLeft;
                StEvalLeft:   state_q <= StUpdate;
                StUpdate: begin
                    for (int e = 0; e < 4; e++) begin
`ifdef COLL_HYST_EN
                        blocked_q[e] <= (hit_cnt_q[e] == DebCnt) ||
                                        (blocked_q[e] && (miss_cnt_q[e] != DebCnt));
`else
                        blocked_q[e] <= (hit_cnt_q[e] == DebCnt);
`endif
                    end
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign blocked_top    = blocked_q[0];
    assign blocked_bottom = blocked_q[1];
    assign blocked_right  = blocked_q[2];
    assign blocked_left   = blocked_q[3];

endmodule

// File: tb/tb_collision_decider.sv
// Self-checking bench for collision_decider: directed frame table, random frames against a
// history-window model, plus overrun and mid-evaluation reset sequences.
module tb_collision_decider;

    localparam logic [9:0] THR = 10'd384;
    localparam bit         POL = 1'b1;
    localparam int         DEB = 2;

    localparam logic [23:0] H = 24'h808080;  // sum 384
    localparam logic [23:0] L = 24'h80807F;  // sum 383
    localparam logic [23:0] Z = 24'h000000;
    localparam logic [23:0] F = 24'hFFFFFF;  // sum 765

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stats_valid = 1'b0;
    logic        clear_ovr = 1'b0;
    logic [71:0] stats_top = '0, stats_bottom = '0, stats_right = '0, stats_left = '0;
    logic        blocked_top, blocked_bottom, blocked_right, blocked_left;
    logic        result_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    collision_decider #(
        .HIT_THR (THR),
        .HIT_POL (POL),
        .DEBOUNCE(DEB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stats_valid   (stats_valid),
        .stats_top     (stats_top),
        .stats_bottom  (stats_bottom),
        .stats_right   (stats_right),
        .stats_left    (stats_left),
        .clear_ovr     (clear_ovr),
        .blocked_top   (blocked_top),
        .blocked_bottom(blocked_bottom),
        .blocked_right (blocked_right),
        .blocked_left  (blocked_left),
        .result_valid  (result_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Model: per edge, a window of hit/miss history bits (newest in bit 0) and the block flag.
    int unsigned win   [4];
    int          nfr   [4];
    bit          m_blk [4];

    function automatic bit on_side(input int s);
        return POL ? (s >= int'(THR)) : (s < int'(THR));
    endfunction

    function automatic int byte_sum(input logic [71:0] st, input int base);
        return int'(st[base+16 +: 8]) + int'(st[base+8 +: 8]) + int'(st[base +: 8]);
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 4; e++) begin
            win[e]   = 0;
            nfr[e]   = 0;
            m_blk[e] = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [71:0] t, b, r, l);
        logic [71:0] st [4];
        int unsigned mask;
        bit h, all_hit, all_miss;
        mask  = (32'd1 << DEB) - 1;
        st[0] = t;
        st[1] = b;
        st[2] = r;
        st[3] = l;
        for (int e = 0; e < 4; e++) begin
            h = on_side(byte_sum(st[e], 0));
`ifdef COLL_HYST_EN
            if (m_blk[e] && !on_side(byte_sum(st[e], 24))) h = 1'b0;
`endif
            win[e]   = (win[e] << 1) | {31'd0, h};
            nfr[e]   = nfr[e] + 1;
            all_hit  = (nfr[e] >= DEB) && ((win[e] & mask) == mask);
            all_miss = (nfr[e] >= DEB) && ((win[e] & mask) == 0);
`ifdef COLL_HYST_EN
            m_blk[e] = all_hit || (m_blk[e] && !all_miss);
`else
            m_blk[e] = all_hit;
`endif
        end
    endtask

    function automatic logic [3:0] model_flags();
        return {m_blk[0], m_blk[1], m_blk[2], m_blk[3]};
    endfunction

    function automatic logic [3:0] dut_flags();
        return {blocked_top, blocked_bottom, blocked_right, blocked_left};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [23:0] avg, input logic [23:0] mn);
        return {24'($urandom), mn, avg};
    endfunction

    task automatic scramble();
        stats_top    = 72'({$urandom, $urandom, $urandom});
        stats_bottom = 72'({$urandom, $urandom, $urandom});
        stats_right  = 72'({$urandom, $urandom, $urandom});
        stats_left   = 72'({$urandom, $urandom, $urandom});
    endtask

    // One full frame: launch, check latency, busy length, single-cycle pulse and flags.
    task automatic do_frame(input logic [71:0] t, b, r, l, output logic [3:0] got);
        int k;
        int bcnt;
        @(negedge clk);
        stats_top    = t;
        stats_bottom = b;
        stats_right  = r;
        stats_left   = l;
        stats_valid  = 1'b1;
        @(negedge clk);
        stats_valid = 1'b0;
        scramble();
        k    = 0;
        bcnt = 0;
        while (!result_valid && k < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            k++;
        end
        check("latency", k, 5);
        check("busy_len", bcnt, 5);
        check("busy_done", {31'd0, busy}, 0);
        got = dut_flags();
        model_frame(t, b, r, l);
        check("model_flags", {28'd0, got}, {28'd0, model_flags()});
        @(negedge clk);
        check("rv_pulse", {31'd0, result_valid}, 0);
        check("flags_hold", {28'd0, dut_flags()}, {28'd0, got});
    endtask

    function automatic logic [23:0] rnd_avg();
        logic [7:0] c;
        case ($urandom_range(0, 4))
            0: return Z;
            1: return F;
            2: begin
                c = 8'h7E + 8'($urandom_range(0, 4));
                return {8'h80, 8'h80, c};
            end
            default: return 24'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [23:0] t, b, r, l, top_min;
        logic [3:0]  exp, exp_hyst;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [3:0]  got, exp;
        logic [71:0] st_t, st_b, st_r, st_l;
        logic [23:0] a;
        int          rv_cnt;
        int          rv_at;

        tbl[0]  = '{H, Z, Z, Z, H, 4'b0000, 4'b0000};
        tbl[1]  = '{H, Z, Z, Z, H, 4'b1000, 4'b1000};
        tbl[2]  = '{L, H, Z, Z, L, 4'b0000, 4'b1000};
        tbl[3]  = '{L, H, Z, Z, L, 4'b0100, 4'b0100};
        tbl[4]  = '{L, Z, Z, Z, L, 4'b0000, 4'b0100};
        tbl[5]  = '{L, Z, Z, Z, L, 4'b0000, 4'b0000};
        tbl[6]  = '{F, Z, F, F, F, 4'b0000, 4'b0000};
        tbl[7]  = '{F, Z, F, F, F, 4'b1011, 4'b1011};
        tbl[8]  = '{F, Z, F, Z, F, 4'b1010, 4'b1011};
        tbl[9]  = '{F, Z, F, Z, F, 4'b1010, 4'b1010};
        tbl[10] = '{F, Z, Z, Z, F, 4'b1000, 4'b1010};
        tbl[11] = '{Z, Z, Z, Z, Z, 4'b0000, 4'b1000};
        tbl[12] = '{Z, Z, Z, Z, Z, 4'b0000, 4'b0000};
        tbl[13] = '{F, Z, Z, Z, F, 4'b0000, 4'b0000};
        tbl[14] = '{F, Z, Z, Z, F, 4'b1000, 4'b1000};
        tbl[15] = '{F, Z, Z, Z, Z, 4'b1000, 4'b1000};
        tbl[16] = '{F, Z, Z, Z, Z, 4'b1000, 4'b0000};

        // Reset held for three cycles.
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_flags", {28'd0, dut_flags()}, 0);
        check("rst_rv", {31'd0, result_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ovr", {31'd0, overrun}, 0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            st_t = mk(tbl[i].t, tbl[i].top_min);
            st_b = mk(tbl[i].b, tbl[i].b);
            st_r = mk(tbl[i].r, tbl[i].r);
            st_l = mk(tbl[i].l, tbl[i].l);
            do_frame(st_t, st_b, st_r, st_l, got);
`ifdef COLL_HYST_EN
            exp = tbl[i].exp_hyst;
`else
            exp = tbl[i].exp;
`endif
            check($sformatf("vec%0d_flags", i), {28'd0, got}, {28'd0, exp});
        end

        for (int i = 0; i < 40; i++) begin
            a    = rnd_avg();
            st_t = mk(a, ($urandom_range(0, 1) != 0) ? a : rnd_avg());
            a    = rnd_avg();
            st_b = mk(a, ($urandom_range(0, 1) != 0) ? a : rnd_avg());
            a    = rnd_avg();
            st_r = mk(a, ($urandom_range(0, 1) != 0) ? a : rnd_avg());
            a    = rnd_avg();
            st_l = mk(a, ($urandom_range(0, 1) != 0) ? a : rnd_avg());
            do_frame(st_t, st_b, st_r, st_l, got);
        end

        // Overrun: second pulse at E2 (with clear_ovr in the same cycle) must be dropped.
        do_frame(mk(F, F), mk(F, F), mk(F, F), mk(F, F), got);
        check("ovr_idle", {31'd0, overrun}, 0);
        st_t = mk(F, F);
        @(negedge clk);
        stats_top    = st_t;
        stats_bottom = st_t;
        stats_right  = st_t;
        stats_left   = st_t;
        stats_valid  = 1'b1;
        @(negedge clk);
        stats_valid = 1'b0;
        @(negedge clk);
        stats_top    = mk(Z, Z);
        stats_bottom = mk(Z, Z);
        stats_right  = mk(Z, Z);
        stats_left   = mk(Z, Z);
        stats_valid  = 1'b1;
        clear_ovr    = 1'b1;
        @(negedge clk);
        stats_valid = 1'b0;
        clear_ovr   = 1'b0;
        check("ovr_set_wins", {31'd0, overrun}, 1);
        model_frame(st_t, st_t, st_t, st_t);
        rv_cnt = 0;
        rv_at  = -1;
        for (int k = 2; k < 14; k++) begin
            if (result_valid) begin
                rv_cnt++;
                rv_at = k;
                check("ovr_flags", {28'd0, dut_flags()}, {28'd0, model_flags()});
            end
            @(negedge clk);
        end
        check("ovr_rv_count", rv_cnt, 1);
        check("ovr_rv_cycle", rv_at, 5);
        check("ovr_sticky", {31'd0, overrun}, 1);
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        check("ovr_clear", {31'd0, overrun}, 0);

        // Reset during EVAL_RIGHT with blocked_left set.
        do_frame(mk(Z, Z), mk(Z, Z), mk(Z, Z), mk(F, F), got);
        do_frame(mk(Z, Z), mk(Z, Z), mk(Z, Z), mk(F, F), got);
        check("pre_rst_left", {31'd0, blocked_left}, 1);
        @(negedge clk);
        stats_top    = mk(F, F);
        stats_bottom = mk(F, F);
        stats_right  = mk(F, F);
        stats_left   = mk(F, F);
        stats_valid  = 1'b1;
        @(negedge clk);
        stats_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_flags", {28'd0, dut_flags()}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_rv", {31'd0, result_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rv_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (result_valid || busy) rv_cnt++;
        end
        check("aborted_no_rv", rv_cnt, 0);
        do_frame(mk(Z, Z), mk(Z, Z), mk(Z, Z), mk(F, F), got);
        check("fresh_history", {28'd0, got}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
